// File: rtl/sarray_pkg.sv
// Shared types for the systolic array front-end sequencers:
// tile instruction encodings, sequencer FSM states and default sizes.
package sarray_pkg;

  localparam int DEF_ADDR_W   = 64;
  localparam int DEF_DATA_W   = 512;
  localparam int DEF_MAX_ROWS = 64;
  localparam int DEF_MAX_OUT  = 8;
  localparam int DEF_PREC_W   = 2;

  typedef enum logic [1:0] {
    TINST_TMMA     = 2'd0,
    TINST_PRELOADA = 2'd1,
    TINST_PRELOADC = 2'd2,
    TINST_RSVD     = 2'd3
  } tinst_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sarray_load_seq_if.sv
// Bundle of the load sequencer's instruction, ar/r, A-buffer,
// stream and completion signals. slave = sequencer side.
interface sarray_load_seq_if #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int MAX_ROWS = 64,
  parameter int PREC_W   = 2
);
  localparam int CNT_W = $clog2(MAX_ROWS);

  logic              inst_valid_i;
  logic              inst_ready_o;
  logic [1:0]        inst_type_i;
  logic [ADDR_W-1:0] inst_base_i;
  logic [ADDR_W-1:0] inst_stride_i;
  logic [CNT_W:0]    inst_rows_i;
  logic [PREC_W-1:0] inst_prec_i;
  logic              inst_acc_i;

  logic              ar_valid_o;
  logic              ar_ready_i;
  logic [ADDR_W-1:0] ar_addr_o;

  logic              r_valid_i;
  logic              r_ready_o;
  logic [DATA_W-1:0] r_data_i;

  logic              buf_wr_valid_o;
  logic              buf_wr_id_o;
  logic [CNT_W-1:0]  buf_wr_addr_o;
  logic [DATA_W-1:0] buf_wr_data_o;
  logic              abuf_rd_id_o;

  logic              st_valid_o;
  logic              st_ready_i;
  logic              st_type_o;
  logic [CNT_W-1:0]  st_cnt_o;
  logic [PREC_W-1:0] st_prec_o;
  logic              st_acc_o;
  logic [DATA_W-1:0] st_data_o;

  logic              done_o;
  logic [1:0]        done_type_o;

  modport slave (
    input  inst_valid_i, inst_type_i, inst_base_i,
    input  inst_stride_i, inst_rows_i, inst_prec_i,
    input  inst_acc_i, ar_ready_i, r_valid_i,
    input  r_data_i, st_ready_i,
    output inst_ready_o, ar_valid_o, ar_addr_o,
    output r_ready_o, buf_wr_valid_o, buf_wr_id_o,
    output buf_wr_addr_o, buf_wr_data_o, abuf_rd_id_o,
    output st_valid_o, st_type_o, st_cnt_o,
    output st_prec_o, st_acc_o, st_data_o,
    output done_o, done_type_o
  );

  modport master (
    output inst_valid_i, inst_type_i, inst_base_i,
    output inst_stride_i, inst_rows_i, inst_prec_i,
    output inst_acc_i, ar_ready_i, r_valid_i,
    output r_data_i, st_ready_i,
    input  inst_ready_o, ar_valid_o, ar_addr_o,
    input  r_ready_o, buf_wr_valid_o, buf_wr_id_o,
    input  buf_wr_addr_o, buf_wr_data_o, abuf_rd_id_o,
    input  st_valid_o, st_type_o, st_cnt_o,
    input  st_prec_o, st_acc_o, st_data_o,
    input  done_o, done_type_o
  );

endinterface

// File: rtl/sarray_credit_cnt.sv
// Up/down outstanding-request counter with a full flag; used by
// the load and store sequencers to bound in-flight reads/writes.
module sarray_credit_cnt #(
  parameter  int MAX = 8,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full
);

  logic up;
  logic dn;

  assign full = (cnt == W'(MAX));
  assign up   = inc && !full;
  assign dn   = dec && (cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (up && !dn) begin
      cnt <= cnt + W'(1);
    end else if (dn && !up) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/sarray_load_seq.sv
// Tile-load sequencer: strided row reads on ar/r, routed to the
// double-buffered A-buffer or to the left/top shift stream.
module sarray_load_seq
  import sarray_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_ROWS = DEF_MAX_ROWS,
  parameter int MAX_OUT  = DEF_MAX_OUT,
  parameter int PREC_W   = DEF_PREC_W
) (
  input logic           clk,
  input logic           rst_n,
  sarray_load_seq_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_ROWS);
  localparam int ROW_W = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  state_e            state;
  state_e            nxt;
  tinst_e            type_r;
  tinst_e            type_in;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] stride_r;
  logic [ROW_W-1:0]  rows_r;
  logic [ROW_W-1:0]  ar_cnt;
  logic [ROW_W-1:0]  r_cnt;
  logic [PREC_W-1:0] prec_r;
  logic              acc_r;
  logic              wr_bank;
  logic              rd_bank;
  logic [OUT_W-1:0]  out_cnt;
  logic              credit_full;
  logic [DATA_W-1:0] row_data;

  logic active;
  logic is_pa;
  logic accept;
  logic ar_valid;
  logic ar_hs;
  logic r_ready;
  logic r_hs;
  logic done;

  assign type_in  = tinst_e'(bus.inst_type_i);
  assign active   = (state == S_RUN) || (state == S_DRAIN);
  assign is_pa    = (type_r == TINST_PRELOADA);
  assign accept   = (state == S_IDLE) && bus.inst_valid_i;
  assign ar_valid = (state == S_RUN) && (ar_cnt < rows_r)
                 && !credit_full;
  assign ar_hs    = ar_valid && bus.ar_ready_i;
  assign r_ready  = active && (is_pa || bus.st_ready_i);
  assign r_hs     = bus.r_valid_i && r_ready;
  assign row_data = bus.r_data_i;

  sarray_credit_cnt #(
    .MAX (MAX_OUT)
  ) u_credit (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .inc  (ar_hs),
    .dec  (r_hs),
    .cnt  (out_cnt),
    .full (credit_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.inst_rows_i == '0 || type_in == TINST_RSVD)
            nxt = S_DONE;
          else
            nxt = S_RUN;
        end
      end
      S_RUN: begin
        // leave as soon as the last request is handed off
        if (ar_cnt + ROW_W'(ar_hs) == rows_r) nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt == rows_r) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_r   <= TINST_TMMA;
      addr_r   <= '0;
      stride_r <= '0;
      rows_r   <= '0;
      prec_r   <= '0;
      acc_r    <= 1'b0;
      ar_cnt   <= '0;
      r_cnt    <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
    end else begin
      if (accept) begin
        type_r   <= type_in;
        addr_r   <= bus.inst_base_i;
        stride_r <= bus.inst_stride_i;
        rows_r   <= bus.inst_rows_i;
        prec_r   <= bus.inst_prec_i;
        acc_r    <= bus.inst_acc_i;
        ar_cnt   <= '0;
        r_cnt    <= '0;
        if (type_in == TINST_PRELOADA) wr_bank <= ~wr_bank;
      end
      if (ar_hs) begin
        addr_r <= addr_r + stride_r;
        ar_cnt <= ar_cnt + ROW_W'(1);
      end
      if (r_hs) r_cnt <= r_cnt + ROW_W'(1);
      // TMMA reads switch to the new bank only once it is complete
      if (done && is_pa) rd_bank <= wr_bank;
    end
  end

  assign bus.inst_ready_o   = (state == S_IDLE);
  assign bus.ar_valid_o     = ar_valid;
  assign bus.ar_addr_o      = addr_r;
  assign bus.r_ready_o      = r_ready;
  assign bus.buf_wr_valid_o = r_hs && is_pa;
  assign bus.buf_wr_id_o    = wr_bank;
  assign bus.buf_wr_addr_o  = r_cnt[CNT_W-1:0];
  assign bus.buf_wr_data_o  = row_data;
  assign bus.abuf_rd_id_o   = rd_bank;
  assign bus.st_valid_o     = bus.r_valid_i && active && !is_pa;
  assign bus.st_type_o      = (type_r == TINST_PRELOADC);
  assign bus.st_cnt_o       = r_cnt[CNT_W-1:0];
  assign bus.st_prec_o      = prec_r;
  assign bus.st_acc_o       = acc_r;
  assign bus.st_data_o      = row_data;
  assign bus.done_o         = done;
  assign bus.done_type_o    = done ? type_r : 2'b00;

endmodule

// File: tb/tb_sarray_load_seq.sv
// Directed bench for sarray_load_seq with a latency-programmable
// memory responder and scoreboard queues for ar, beats and done.
module tb_sarray_load_seq;
  import sarray_pkg::*;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int MR = 16;
  localparam int MO = 3;
  localparam int PW = 2;
  localparam int CW = $clog2(MR);
  localparam int RW = CW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sarray_load_seq_if #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_ROWS(MR), .PREC_W(PW)
  ) bus ();

  sarray_load_seq #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_ROWS(MR),
    .MAX_OUT(MO), .PREC_W(PW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          dst;
    logic          id;
    logic [CW-1:0] cnt;
    logic [DW-1:0] data;
    logic          st_type;
    logic [PW-1:0] prec;
    logic          acc;
  } beat_t;

  beat_t         exp_beat_q[$];
  logic [AW-1:0] exp_ar_q[$];
  logic [1:0]    exp_done_q[$];
  logic [AW-1:0] pend_q[$];
  int            pend_t[$];

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   outst = 0;
  int   lat = 0;
  int   stalls = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic ar_rdy_en = 1'b1;
  logic [3:0] st_pat = 4'hF;
  logic wr_bank_m = 1'b0;

  function automatic logic [DW-1:0] rdata(input logic [AW-1:0] a);
    return a[DW-1:0] ^ a[AW-1:AW-DW] ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs,
                     input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take_beat(input logic st);
    beat_t e;
    chk("beat_expected", exp_beat_q.size() != 0, 1);
    if (exp_beat_q.size() == 0) return;
    e = exp_beat_q.pop_front();
    chk("beat_dst", st, e.dst);
    if (st) begin
      chk("st_data", bus.st_data_o, e.data);
      chk("st_cnt", bus.st_cnt_o, e.cnt);
      chk("st_type", bus.st_type_o, e.st_type);
      chk("st_prec", bus.st_prec_o, e.prec);
      chk("st_acc", bus.st_acc_o, e.acc);
    end else begin
      chk("buf_data", bus.buf_wr_data_o, e.data);
      chk("buf_addr", bus.buf_wr_addr_o, e.cnt);
      chk("buf_id", bus.buf_wr_id_o, e.id);
    end
  endtask

  // responder and per-cycle ready drivers
  initial begin
    bus.ar_ready_i = 1'b0;
    bus.st_ready_i = 1'b0;
    bus.r_valid_i  = 1'b0;
    bus.r_data_i   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ar_ready_i = ar_rdy_en;
      bus.st_ready_i = st_pat[cyc % 4];
      if (pend_q.size() != 0 && pend_t[0] <= cyc) begin
        bus.r_valid_i = 1'b1;
        bus.r_data_i  = rdata(pend_q[0]);
      end else begin
        bus.r_valid_i = 1'b0;
        bus.r_data_i  = '0;
      end
    end
  end

  // monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      chk("out_cnt", u_dut.out_cnt, outst);
      if (outst == MO) begin
        chk("ar_stall", bus.ar_valid_o, 0);
        stalls++;
      end
      if (bus.ar_valid_o) begin
        chk("ar_expected", exp_ar_q.size() != 0, 1);
        if (exp_ar_q.size() != 0) begin
          chk("ar_addr", bus.ar_addr_o, exp_ar_q[0]);
          if (bus.ar_ready_i) begin
            void'(exp_ar_q.pop_front());
            pend_q.push_back(bus.ar_addr_o);
            pend_t.push_back(cyc + lat);
            outst++;
          end
        end
      end
      if (bus.r_valid_i && bus.r_ready_o && pend_q.size() != 0) begin
        void'(pend_q.pop_front());
        void'(pend_t.pop_front());
        outst--;
      end
      if (bus.st_valid_o)
        chk("r_ready_follow", bus.r_ready_o, bus.st_ready_i);
      if (bus.buf_wr_valid_o) take_beat(1'b0);
      if (bus.st_valid_o && bus.st_ready_i) take_beat(1'b1);
      if (bus.done_o) begin
        chk("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0)
          chk("done_type", bus.done_type_o, exp_done_q.pop_front());
        chk("done_beats_left", exp_beat_q.size(), 0);
        chk("done_ar_left", exp_ar_q.size(), 0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [1:0] ty, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride, input int rows,
                       input logic [PW-1:0] prec, input logic acc,
                       output int t0);
    logic [AW-1:0] a;
    beat_t b;
    a = base;
    if (ty == TINST_PRELOADA) wr_bank_m = ~wr_bank_m;
    if (ty != TINST_RSVD) begin
      for (int i = 0; i < rows; i++) begin
        exp_ar_q.push_back(a);
        b.dst     = (ty != TINST_PRELOADA);
        b.id      = wr_bank_m;
        b.cnt     = CW'(i);
        b.data    = rdata(a);
        b.st_type = (ty == TINST_PRELOADC);
        b.prec    = prec;
        b.acc     = acc;
        exp_beat_q.push_back(b);
        a = a + stride;
      end
    end
    exp_done_q.push_back(ty);
    @(posedge clk);
    #1;
    chk("inst_ready", bus.inst_ready_o, 1);
    bus.inst_type_i   = ty;
    bus.inst_base_i   = base;
    bus.inst_stride_i = stride;
    bus.inst_rows_i   = RW'(rows);
    bus.inst_prec_i   = prec;
    bus.inst_acc_i    = acc;
    bus.inst_valid_i  = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    bus.inst_valid_i  = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int start;
    start = done_cnt;
    for (int i = 0; i < lim && done_cnt == start; i++)
      @(posedge clk);
    chk("done_timeout", done_cnt != start, 1);
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst_ready", bus.inst_ready_o, 1);
    chk("rst_ar_valid", bus.ar_valid_o, 0);
    chk("rst_ar_addr", bus.ar_addr_o, 0);
    chk("rst_r_ready", bus.r_ready_o, 0);
    chk("rst_buf_wr", bus.buf_wr_valid_o, 0);
    chk("rst_st_valid", bus.st_valid_o, 0);
    chk("rst_st_cnt", bus.st_cnt_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_done_type", bus.done_type_o, 0);
    chk("rst_abuf_id", bus.abuf_rd_id_o, 0);
  endtask

  initial begin
    int t0;
    int st0;
    int k;
    bus.inst_valid_i  = 1'b0;
    bus.inst_type_i   = '0;
    bus.inst_base_i   = '0;
    bus.inst_stride_i = '0;
    bus.inst_rows_i   = '0;
    bus.inst_prec_i   = '0;
    bus.inst_acc_i    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // PRELOADA into bank 1
    lat = 0;
    issue(TINST_PRELOADA, 64'h1000, 64'h100, 4, 2'd0, 1'b0, t0);
    wait_done(100);
    chk("pa_abuf_id", bus.abuf_rd_id_o, 1);

    // TMMA at MAX_ROWS with slow responses
    lat = 5;
    st0 = stalls;
    issue(TINST_TMMA, 64'h8000, 64'h40, 16, 2'd2, 1'b1, t0);
    wait_done(400);
    chk("credit_stall_seen", stalls > st0, 1);
    chk("tmma_abuf_id", bus.abuf_rd_id_o, 1);

    // PRELOADC under stream backpressure
    lat = 0;
    st_pat = 4'b1001;
    issue(TINST_PRELOADC, 64'h4000, 64'h80, 3, 2'd1, 1'b0, t0);
    wait_done(100);
    st_pat = 4'hF;

    // zero-row TMMA
    issue(TINST_TMMA, 64'h5000, 64'h10, 0, 2'd3, 1'b1, t0);
    wait_done(20);
    chk("zero_done_lat", done_cyc - t0, 2);
    chk("zero_inst_ready", bus.inst_ready_o, 1);

    // reserved type with nonzero rows is a no-op
    issue(TINST_RSVD, 64'h6000, 64'h10, 5, 2'd0, 1'b0, t0);
    wait_done(20);

    // address wrap, back-to-back ar and r
    issue(TINST_TMMA, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 2,
          2'd1, 1'b0, t0);
    wait_done(100);

    // abort in DRAIN with three reads in flight
    lat = 20;
    issue(TINST_PRELOADA, 64'h3000, 64'h20, 3, 2'd0, 1'b0, t0);
    k = 0;
    while (outst != MO && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("pre_rst_outst", outst, MO);
    chk("pre_rst_drain", u_dut.state, S_DRAIN);
    rst_n = 1'b0;
    exp_ar_q.delete();
    exp_beat_q.delete();
    exp_done_q.delete();
    pend_q.delete();
    pend_t.delete();
    outst = 0;
    wr_bank_m = 1'b0;
    lat = 0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(TINST_PRELOADA, 64'h2000, 64'h40, 4, 2'd0, 1'b0, t0);
    wait_done(100);
    chk("post_rst_abuf_id", bus.abuf_rd_id_o, 1);
    chk("post_rst_inst_ready", bus.inst_ready_o, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
